dct_2d_8x8: RTL and testbench
=============================

DCT_2D_8X8 -- requirements
Module: dct_2d_8x8

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the bit width of one signed Q16.16 sample.
REQ-002 The module SHALL have parameter DATA_DEPTH, default 8, the matrix dimension; only 8 is required to be supported.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port data_in_matrix, input, DATA_WIDTH*DATA_DEPTH*DATA_DEPTH (2048) bits: 64 signed Q16.16 samples.
REQ-006 Port data_out_matrix, output, 2048 bits: 64 signed Q16.16 DCT coefficients, registered.
REQ-007 Element k = r*8 + c (row r, column c, row-major) SHALL occupy bits [k*32 +: 32] of both matrices.

Function
REQ-008 Output SHALL be the orthonormal 2D DCT-II: X(u,v) = 1/4 * C(u) * C(v) * sum over r,c of x(r,c)*cos((2r+1)u*pi/16)*cos((2c+1)v*pi/16), with C(0) = 1/sqrt(2) and C(k>0) = 1; X(u,v) is placed at element u*8+v.
REQ-009 No level shift SHALL be applied; inputs are used as given, as signed Q16.16.
REQ-010 Computation SHALL be separable: stage 1 applies a 1D 8-point DCT to each row, and stage 2 applies a 1D 8-point DCT to each column of the stage-1 result.
REQ-011 Cosine coefficients SHALL be signed constants with at least 16 fractional bits; products and sums SHALL use at least 64-bit signed accumulators.
REQ-012 Each stage result SHALL be rescaled to Q16.16 by an arithmetic right shift with round-half-up, i.e. add 2^(F-1) before shifting by F.
REQ-013 Final values SHALL be truncated to 32 bits with two's-complement wrap and no saturation; in-range results are guaranteed only for |x| < 2^12.
REQ-014 Each output element SHALL be within 0x00008000 (0.5) of the exact real-valued DCT of the input.
REQ-015 Stage 1 and stage 2 results SHALL each be registered, giving a fixed latency of exactly 2 clk cycles from data_in_matrix to data_out_matrix.
REQ-016 The block SHALL be fully pipelined with no handshake: a new matrix is accepted every cycle, and the output follows the input 2 cycles later.
REQ-017 With static input, the output SHALL remain constant from the 2nd rising edge after reset release onward.

Reset
REQ-018 While reset_n is low, all pipeline registers and data_out_matrix SHALL be 0, independent of clk.
REQ-019 Asserting reset_n mid-operation SHALL immediately clear all registers and discard in-flight matrices.
REQ-020 After reset_n rises, the first valid output SHALL appear 2 rising edges later; the zero output before then SHALL be considered valid reset state.

Verification
REQ-021 All inputs 0 -> all 64 outputs 0x00000000 after 2 cycles.
REQ-022 All inputs 0x00010000 (1.0) -> element 0 = 0x00080000 (8.0), elements 1..63 within ±0x8000 of 0.
REQ-023 All inputs 0x00FF0000 (255.0) -> element 0 = 0x07F80000 (2040.0), others within ±0x8000 of 0.
REQ-024 Impulse x(0,0) = 0x00010000, others 0 -> element 0 = 0x00002000 (0.125), element u*8+v = 0.25*C(u)*C(v)*cos(u*pi/16)*cos(v*pi/16) within tolerance.
REQ-025 Latency/reset: change the input matrix at edge n -> the new result appears at edge n+2; pulse reset_n low mid-stream -> output is 0 immediately and valid again 2 edges after release.
REQ-026 Random 8x8 matrices with |x| < 256.0 -> every element within 0x8000 of a floating-point DCT model.

Source files
------------

// File: rtl/dct_2d_8x8.sv
// ============================================================================
// Module   : dct_2d_8x8
// Brief    : Fully pipelined 8x8 orthonormal 2D DCT-II on signed Q16.16
//            samples; row pass then column pass, each registered (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_2d_8x8 #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_in_matrix,
    output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_out_matrix
);

    localparam int c_n     = DATA_DEPTH;
    localparam int c_frac  = 20;
    localparam int c_acc_w = 64;
    localparam int c_mat_w = DATA_WIDTH * c_n * c_n;
    localparam logic signed [63:0] c_round = 64'sd1 <<< (c_frac - 1);

    // Orthonormal 8-point DCT basis entry C(u)/2 * cos((2n+1)u*pi/16) in Q.20.
    // The angle is folded into the first quadrant so one magnitude table serves.
    function automatic logic signed [c_acc_w-1:0] dct_coef(input int u, input int n);
        int                        m;
        logic                      neg;
        logic signed [c_acc_w-1:0] mag;
        m   = ((2 * n + 1) * u) % 32;
        neg = 1'b0;
        if (m > 24) begin
            m = 32 - m;
        end else if (m > 16) begin
            m   = m - 16;
            neg = 1'b1;
        end else if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        case (m)
            0:       mag = 64'sd524288;
            1:       mag = 64'sd514214;
            2:       mag = 64'sd484379;
            3:       mag = 64'sd435930;
            4:       mag = 64'sd370728;
            5:       mag = 64'sd291279;
            6:       mag = 64'sd200636;
            7:       mag = 64'sd102284;
            default: mag = 64'sd0;
        endcase
        if (u == 0) begin
            mag = 64'sd370728;
        end
        return neg ? -mag : mag;
    endfunction

    logic signed [DATA_WIDTH-1:0] w_x  [c_n][c_n];
    logic signed [DATA_WIDTH-1:0] w_s1 [c_n][c_n];
    logic signed [DATA_WIDTH-1:0] r_s1 [c_n][c_n];
    logic        [c_mat_w-1:0]    w_s2_flat;
    logic        [c_mat_w-1:0]    r_out;

    for (genvar gr = 0; gr < c_n; gr++) begin : g_unpack_row
        for (genvar gc = 0; gc < c_n; gc++) begin : g_unpack_col
            assign w_x[gr][gc] = $signed(data_in_matrix[(gr*c_n+gc)*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Row pass: w_s1[r][u] = sum_c x[r][c] * K(u,c), rounded back to Q16.16.
    for (genvar gr = 0; gr < c_n; gr++) begin : g_row
        for (genvar gu = 0; gu < c_n; gu++) begin : g_row_freq
            logic signed [c_acc_w-1:0] w_prod [c_n];
            logic signed [c_acc_w-1:0] w_sum;

            for (genvar gc = 0; gc < c_n; gc++) begin : g_tap
                localparam logic signed [c_acc_w-1:0] c_k = dct_coef(gu, gc);
                assign w_prod[gc] = c_acc_w'(w_x[gr][gc]) * c_k;
            end

            always_comb begin
                w_sum = c_round;
                for (int i = 0; i < c_n; i++) begin
                    w_sum = w_sum + w_prod[i];
                end
            end

            assign w_s1[gr][gu] = DATA_WIDTH'(w_sum >>> c_frac);
        end
    end

    // Column pass on the registered row result: X(u,v) = sum_r s1[r][v] * K(u,r).
    for (genvar gu = 0; gu < c_n; gu++) begin : g_col_freq
        for (genvar gv = 0; gv < c_n; gv++) begin : g_col
            logic signed [c_acc_w-1:0] w_prod [c_n];
            logic signed [c_acc_w-1:0] w_sum;

            for (genvar gr = 0; gr < c_n; gr++) begin : g_tap
                localparam logic signed [c_acc_w-1:0] c_k = dct_coef(gu, gr);
                assign w_prod[gr] = c_acc_w'(r_s1[gr][gv]) * c_k;
            end

            always_comb begin
                w_sum = c_round;
                for (int i = 0; i < c_n; i++) begin
                    w_sum = w_sum + w_prod[i];
                end
            end

            assign w_s2_flat[(gu*c_n+gv)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum >>> c_frac);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < c_n; r++) begin
                for (int c = 0; c < c_n; c++) begin
                    r_s1[r][c] <= '0;
                end
            end
            r_out <= '0;
        end else begin
            for (int r = 0; r < c_n; r++) begin
                for (int c = 0; c < c_n; c++) begin
                    r_s1[r][c] <= w_s1[r][c];
                end
            end
            r_out <= w_s2_flat;
        end
    end

    assign data_out_matrix = r_out;

endmodule

`default_nettype wire

// File: tb/tb_dct_2d_8x8.sv
// ============================================================================
// Module   : tb_dct_2d_8x8
// Brief    : Self-checking bench for dct_2d_8x8: directed vector table,
//            latency / pipelining / reset sequences and random matrices.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dct_2d_8x8;

    localparam int  c_w    = 32;
    localparam int  c_n    = 8;
    localparam int  c_bits = c_w * c_n * c_n;
    localparam real c_pi   = 3.14159265358979323846;
    localparam int  c_nvec = 18;

    typedef struct {
        int          pat;   // 0: every element = val, 1: only element (0,0) = val
        logic [31:0] val;
        int          elem;
        logic [31:0] exp;
        int          tol;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [c_bits-1:0] data_in_matrix;
    logic [c_bits-1:0] data_out_matrix;

    int   total = 0;
    int   bad   = 0;
    vec_t vt [c_nvec];

    always #5 clk = ~clk;

    dct_2d_8x8 #(
        .DATA_WIDTH (c_w),
        .DATA_DEPTH (c_n)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .data_in_matrix  (data_in_matrix),
        .data_out_matrix (data_out_matrix)
    );

    task automatic drive(input int pat, input logic [31:0] val);
        data_in_matrix = '0;
        if (pat == 0) begin
            for (int k = 0; k < c_n * c_n; k++) begin
                data_in_matrix[k*c_w +: c_w] = val;
            end
        end else begin
            data_in_matrix[c_w-1:0] = val;
        end
    endtask

    task automatic check(input string name, input int k, input logic [31:0] exp, input int tol);
        logic [31:0] act;
        int          diff;
        act  = data_out_matrix[k*c_w +: c_w];
        diff = $signed(act - exp);
        total++;
        if (diff > tol || diff < -tol) begin
            bad++;
            $display("FAIL %s elem=%0d got=0x%08h want=0x%08h tol=0x%0h", name, k, act, exp, tol);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int idx);
        real x [c_n][c_n];
        real acc;
        real cu;
        real cv;
        real exp_q;
        real act_q;
        int  s;
        @(negedge clk);
        for (int r = 0; r < c_n; r++) begin
            for (int c = 0; c < c_n; c++) begin
                s = int'($urandom_range(0, 33554430)) - 16777215;
                data_in_matrix[(r*c_n+c)*c_w +: c_w] = s;
                x[r][c] = real'(s) / 65536.0;
            end
        end
        settle();
        for (int u = 0; u < c_n; u++) begin
            for (int v = 0; v < c_n; v++) begin
                acc = 0.0;
                for (int r = 0; r < c_n; r++) begin
                    for (int c = 0; c < c_n; c++) begin
                        acc = acc + x[r][c] * $cos(real'((2*r+1)*u) * c_pi / 16.0)
                                            * $cos(real'((2*c+1)*v) * c_pi / 16.0);
                    end
                end
                cu    = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                cv    = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                exp_q = 0.25 * cu * cv * acc * 65536.0;
                act_q = real'($signed(data_out_matrix[(u*c_n+v)*c_w +: c_w]));
                total++;
                if (act_q - exp_q > 32768.0 || exp_q - act_q > 32768.0) begin
                    bad++;
                    $display("FAIL random%0d elem=%0d got=%0.1f want=%0.1f (Q16.16 LSBs)",
                             idx, u*c_n+v, act_q, exp_q);
                end
            end
        end
    endtask

    initial begin
        // {pattern, value, element, expected, tolerance}
        vt[0]  = '{0, 32'h0000_0000,  0, 32'h0000_0000, 0};
        vt[1]  = '{0, 32'h0000_0000, 63, 32'h0000_0000, 0};
        vt[2]  = '{0, 32'h0001_0000,  0, 32'h0008_0000, 32'h100};
        vt[3]  = '{0, 32'h0001_0000,  1, 32'h0000_0000, 32'h100};
        vt[4]  = '{0, 32'h0001_0000, 36, 32'h0000_0000, 32'h100};
        vt[5]  = '{0, 32'h0001_0000, 63, 32'h0000_0000, 32'h100};
        vt[6]  = '{0, 32'h00FF_0000,  0, 32'h07F8_0000, 32'h8000};
        vt[7]  = '{0, 32'h00FF_0000,  8, 32'h0000_0000, 32'h8000};
        vt[8]  = '{0, 32'h00FF_0000, 63, 32'h0000_0000, 32'h8000};
        vt[9]  = '{0, 32'hFFFF_0000,  0, 32'hFFF8_0000, 32'h100};
        vt[10] = '{1, 32'h0001_0000,  0, 32'h0000_2000, 32'h10};
        vt[11] = '{1, 32'h0001_0000,  1, 32'h0000_2C63, 32'h10};
        vt[12] = '{1, 32'h0001_0000,  8, 32'h0000_2C63, 32'h10};
        vt[13] = '{1, 32'h0001_0000,  9, 32'h0000_3D90, 32'h10};
        vt[14] = '{1, 32'h0001_0000,  7, 32'h0000_08D4, 32'h10};
        vt[15] = '{1, 32'h0001_0000, 63, 32'h0000_0270, 32'h10};
        // 4096.0 everywhere: DC of 32768.0 wraps to the negative end.
        vt[16] = '{0, 32'h1000_0000,  0, 32'h8000_0000, 32'h8000};
        vt[17] = '{0, 32'h1000_0000, 27, 32'h0000_0000, 32'h8000};

        reset_n = 1'b0;
        drive(0, 32'h00FF_0000);
        #2;
        check("reset_async", 0, 32'h0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_e0", 0, 32'h0, 0);
        check("reset_hold_e63", 63, 32'h0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_edge1", 0, 32'h0, 0);
        @(posedge clk);
        #1;
        check("release_edge2", 0, 32'h07F8_0000, 32'h8000);

        for (int i = 0; i < c_nvec; i++) begin
            @(negedge clk);
            drive(vt[i].pat, vt[i].val);
            settle();
            check($sformatf("vec%0d", i), vt[i].elem, vt[i].exp, vt[i].tol);
        end

        // Latency: new matrix visible on the second edge, not the first.
        @(negedge clk);
        drive(0, 32'h0);
        settle();
        @(negedge clk);
        drive(0, 32'h00FF_0000);
        @(posedge clk);
        #1;
        check("latency_edge1", 0, 32'h0, 0);
        @(posedge clk);
        #1;
        check("latency_edge2", 0, 32'h07F8_0000, 32'h8000);

        // Back-to-back matrices, one per cycle.
        @(negedge clk);
        drive(0, 32'h0001_0000);
        @(negedge clk);
        drive(1, 32'h0001_0000);
        @(posedge clk);
        #1;
        check("pipe_a", 0, 32'h0008_0000, 32'h100);
        @(negedge clk);
        drive(0, 32'hFFFF_0000);
        @(posedge clk);
        #1;
        check("pipe_b", 0, 32'h0000_2000, 32'h10);
        check("pipe_b_e9", 9, 32'h0000_3D90, 32'h10);
        @(posedge clk);
        #1;
        check("pipe_c", 0, 32'hFFF8_0000, 32'h100);

        // Mid-stream reset between edges, with a new matrix in flight.
        @(negedge clk);
        drive(0, 32'h00FF_0000);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_reset_async", 0, 32'h0, 0);
        @(posedge clk);
        #1;
        check("mid_reset_hold", 0, 32'h0, 0);
        @(negedge clk);
        drive(0, 32'hFFFF_0000);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_release_edge1", 0, 32'h0, 0);
        @(posedge clk);
        #1;
        check("mid_release_edge2", 0, 32'hFFF8_0000, 32'h100);

        run_random(0);
        run_random(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
